r2sdf_butterfly_stage: RTL and testbench
========================================

Name: r2sdf_butterfly_stage

Overview:
- Radix-2 single-path delay-feedback (SDF) butterfly stage for the streaming FFT datapath.
- Sits directly upstream of the 0.7071 twiddle multiplier stage.
- Consumes a complex sample stream and produces butterfly sums, passed through untwiddled, and butterfly differences, which the downstream stage twiddles.
- Sums and differences leave on a single valid-qualified output stream, tagged so the downstream stage can tell them apart.

Parameters:
- N, 4: data width is 2**N bits per real/imag component, two's complement.
- LOG_D, 2: delay depth D = 2**LOG_D; frame length is 2*D.
- SCALE, 1: 1 = arithmetic shift right by 1 on every sum/diff; 0 = no scaling, results wrap modulo 2**(2**N).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input sample present
- in_ready  out  1  stage accepts input this cycle
- in_re  in  2**N  input real part
- in_im  in  2**N  input imaginary part
- flush  in  1  request drain of stored differences; sampled only at frame boundary
- out_valid  out  1  output sample valid (one-cycle strobe per sample)
- out_re  out  2**N  output real part
- out_im  out  2**N  output imaginary part
- out_diff  out  1  1 = butterfly difference (needs twiddle); 0 = sum
- out_idx  out  LOG_D  position k (0..D-1) within half-frame, for twiddle select

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - FSM=RUN, cnt=0, primed=0.
  - out_valid=0, out_re=0, out_im=0, out_diff=0, out_idx=0, in_ready=1.
  - Delay-line contents are don't-care; primed=0 masks them.
  - Reset mid-frame or mid-drain discards all state; no output is produced for the discarded data.
- Accept: sample accepted when in_valid && in_ready. cnt (LOG_D+1 bits) increments per accept and wraps 2D-1 -> 0.
- Delay line: D-entry shift register of complex words. It advances only on accept or on a drain step; otherwise it holds. No bubbles are inserted.
- Phase A (cnt < D), on accept:
  - Push x_in into the delay line.
  - The popped word is the difference from the previous frame. If primed=1: out = popped, out_diff=1, out_idx=cnt, out_valid=1. Else out_valid=0.
- Phase B (cnt >= D), on accept:
  - a = popped word, b = x_in.
  - out = (a+b)>>SCALE, out_diff=0, out_idx=cnt-D, out_valid=1.
  - Push (a-b)>>SCALE into the delay line.
  - Set primed=1 on the accept that takes cnt from 2D-1 to 0.
- Arithmetic:
  - Sum and difference are computed at 2**N+1 bits.
  - SCALE=1: arithmetic shift right, truncating toward -inf, then take the low 2**N bits.
  - SCALE=0: take the low 2**N bits (wrap).
  - Real and imaginary parts are processed independently.
- Latency: outputs are registered and appear 1 cycle after the accepting edge. out_valid is low in any cycle with no accept and no drain step.
- FSM:
  - RUN: in_ready=1. If flush=1 && cnt==0 && primed=1 && in_valid=0, go to DRAIN with dcnt=0.
  - flush is ignored when cnt != 0, when primed=0, or when in_valid=1 (the accept wins).
  - DRAIN: in_ready=0. Each cycle: pop one word, output it with out_diff=1, out_idx=dcnt, out_valid=1; push zero; dcnt++.
  - After D steps: primed=0, cnt=0, return to RUN.
  - in_valid during DRAIN is ignored; no accept occurs.
- Back-to-back frames without flush: the diffs of frame f stream out interleaved in time with the first half of frame f+1. Throughput is one sample per clock.

Test Plan (N=4, LOG_D=2, D=4):
- Reset check: hold rst 3 cycles with in_valid=1 and random data -> out_valid=0, outputs 0, in_ready=1; first 4 accepts after release produce no out_valid.
- SCALE=0, frame re=1..8, im=0, continuous, then flush at boundary:
  - Cycles 5-8 give sums 6,8,10,12 with out_diff=0, idx 0..3.
  - DRAIN gives -4,-4,-4,-4 with out_diff=1, idx 0..3; in_ready=0 for those 4 cycles.
- SCALE=1, same frame -> sums 3,4,5,6; diffs -2 each. Imag input 0..7 -> imag sums 2,3,4,5, diffs -2.
- Back-to-back frames 1..8 then 9..16 (SCALE=0):
  - Frame-2 phase A emits diffs -4 x4 (out_diff=1).
  - Frame-2 phase B emits sums 22,24,26,28.
- Stall and overflow:
  - Drop in_valid for 3 cycles mid phase B -> no out_valid during the gap; the sequence resumes intact.
  - SCALE=0 with a=0x7FFF, b=0x0001 -> sum wraps to 0x8000.
- Reset mid-DRAIN (after 2 steps) -> next cycle out_valid=0, in_ready=1; a following frame behaves as the first frame after reset.

Source files
------------

// File: rtl/r2sdf_butterfly_stage.sv
// Radix-2 single-path delay-feedback butterfly stage.
// Phase A: first half-frame samples go into the delay line while the previous
// frame's differences are drained out. Phase B: pops pair with the new samples,
// sums leave at once and differences are fed back into the delay line.
// The real and imaginary paths are two identical lanes.

module r2sdf_bf_lane #(
  parameter int W     = 16,
  parameter int D     = 4,
  parameter int SCALE = 1
) (
  input  logic         clk,
  input  logic         shift,
  input  logic         sel_b,
  input  logic         sel_zero,
  input  logic [W-1:0] x,
  output logic [W-1:0] pop,
  output logic [W-1:0] sum
);
  logic [D-1:0][W-1:0] dl;
  logic signed [W:0]   a_e, b_e, s_f, d_f;
  logic [W-1:0]        d_s, push;

  assign pop = dl[D-1];
  assign a_e = {pop[W-1], pop};
  assign b_e = {x[W-1], x};
  assign s_f = a_e + b_e;
  assign d_f = a_e - b_e;

  // Scale by arithmetic shift (drop the LSB of the W+1 bit result) or wrap.
  always_comb begin
    if (SCALE != 0) begin
      sum = s_f[W:1];
      d_s = d_f[W:1];
    end else begin
      sum = s_f[W-1:0];
      d_s = d_f[W-1:0];
    end
  end

  assign push = sel_zero ? '0 : (sel_b ? d_s : x);

  // Delay line advances only on an accept or a drain step; contents need no reset.
  always_ff @(posedge clk) begin
    if (shift) begin
      dl[0] <= push;
      for (int i = 1; i < D; i++) dl[i] <= dl[i-1];
    end
  end
endmodule

module r2sdf_butterfly_stage #(
  parameter int N     = 4,
  parameter int LOG_D = 2,
  parameter int SCALE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2**N-1:0]    in_re,
  input  logic [2**N-1:0]    in_im,
  input  logic               flush,
  output logic               out_valid,
  output logic [2**N-1:0]    out_re,
  output logic [2**N-1:0]    out_im,
  output logic               out_diff,
  output logic [LOG_D-1:0]   out_idx
);
  localparam int W         = 2**N;
  localparam int D         = 2**LOG_D;
  localparam int NUM_LANES = 2;   // lane 0 = real, lane 1 = imag

  typedef enum logic {RUN, DRAIN} st_t;

  st_t                            state;
  logic [LOG_D:0]                 cnt;
  logic [LOG_D-1:0]               dcnt;
  logic                           primed;
  logic                           accept, drain_step, phase_b, start_drain;
  logic [NUM_LANES-1:0][W-1:0]    x_l, pop_l, sum_l;

  assign in_ready    = (state == RUN);
  assign accept      = in_valid && in_ready;
  assign drain_step  = (state == DRAIN);
  assign phase_b     = cnt[LOG_D];
  assign start_drain = in_ready && !in_valid && flush && (cnt == '0) && primed;
  assign x_l         = {in_im, in_re};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    r2sdf_bf_lane #(.W(W), .D(D), .SCALE(SCALE)) u_lane (
      .clk      (clk),
      .shift    (accept || drain_step),
      .sel_b    (phase_b && !drain_step),
      .sel_zero (drain_step),
      .x        (x_l[g]),
      .pop      (pop_l[g]),
      .sum      (sum_l[g])
    );
  end

  // Control FSM plus registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      cnt       <= '0;
      dcnt      <= '0;
      primed    <= 1'b0;
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_diff  <= 1'b0;
      out_idx   <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        RUN: begin
          if (accept) begin
            cnt <= cnt + 1'b1;   // wraps 2D-1 -> 0 by width
            if (!phase_b) begin
              // Previous frame's difference falls out of the delay line.
              if (primed) begin
                out_valid <= 1'b1;
                out_re    <= pop_l[0];
                out_im    <= pop_l[1];
                out_diff  <= 1'b1;
                out_idx   <= cnt[LOG_D-1:0];
              end
            end else begin
              out_valid <= 1'b1;
              out_re    <= sum_l[0];
              out_im    <= sum_l[1];
              out_diff  <= 1'b0;
              out_idx   <= cnt[LOG_D-1:0];
              if (cnt == '1) primed <= 1'b1;
            end
          end else if (start_drain) begin
            state <= DRAIN;
            dcnt  <= '0;
          end
        end
        DRAIN: begin
          out_valid <= 1'b1;
          out_re    <= pop_l[0];
          out_im    <= pop_l[1];
          out_diff  <= 1'b1;
          out_idx   <= dcnt;
          dcnt      <= dcnt + 1'b1;
          if (dcnt == '1) begin
            state  <= RUN;
            primed <= 1'b0;
            cnt    <= '0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_r2sdf_butterfly_stage.sv
// Bench for r2sdf_butterfly_stage: a SCALE=0 and a SCALE=1 instance share one
// stimulus stream. A frame-level model predicts every output cycle; literal
// tables pin the logged output sequences.

module tb_r2sdf_butterfly_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic flush = 1'b0;
  logic [15:0] in_re = '0, in_im = '0;

  logic        ov[2], ordy[2], odf[2];
  logic [15:0] ore[2], oim[2];
  logic [1:0]  oidx[2];

  always #5 clk = ~clk;

  r2sdf_butterfly_stage #(.N(4), .LOG_D(2), .SCALE(0)) u_s0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ordy[0]),
    .in_re(in_re), .in_im(in_im), .flush(flush), .out_valid(ov[0]),
    .out_re(ore[0]), .out_im(oim[0]), .out_diff(odf[0]), .out_idx(oidx[0]));

  r2sdf_butterfly_stage #(.N(4), .LOG_D(2), .SCALE(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ordy[1]),
    .in_re(in_re), .in_im(in_im), .flush(flush), .out_valid(ov[1]),
    .out_re(ore[1]), .out_im(oim[1]), .out_diff(odf[1]), .out_idx(oidx[1]));

  int ncmp = 0, nerr = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Butterfly on one component: returns {sum, diff}, scaled or wrapped.
  function automatic logic [31:0] bf(input int sc, input logic [15:0] a, input logic [15:0] b);
    int ai, bi, s, d;
    ai = int'($signed(a));
    bi = int'($signed(b));
    s = ai + bi;
    d = ai - bi;
    if (sc != 0) begin
      s = s >>> 1;
      d = d >>> 1;
    end
    return {s[15:0], d[15:0]};
  endfunction

  // Frame-level model: first-half samples, pending differences, drain status.
  logic [15:0] fa_re[2][4], fa_im[2][4], df_re[2][4], df_im[2][4];
  int  mcnt[2], mdc[2];
  bit  mprimed[2], mdrain[2];
  bit  ev[2], echk[2], ed[2], erdy[2];
  logic [15:0] ere[2], eim[2];
  int  eidx[2];

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      logic [31:0] rr, ii;
      int k;
      if (rst) begin
        ev[m] = 0; echk[m] = 1; ere[m] = 0; eim[m] = 0; ed[m] = 0; eidx[m] = 0;
        mcnt[m] = 0; mprimed[m] = 0; mdrain[m] = 0; mdc[m] = 0;
      end else begin
        ev[m] = 0; echk[m] = 0;
        if (mdrain[m]) begin
          ev[m] = 1; echk[m] = 1; ed[m] = 1; eidx[m] = mdc[m];
          ere[m] = df_re[m][mdc[m]]; eim[m] = df_im[m][mdc[m]];
          mdc[m]++;
          if (mdc[m] == 4) begin mdrain[m] = 0; mprimed[m] = 0; mcnt[m] = 0; end
        end else if (in_valid) begin
          k = mcnt[m] % 4;
          if (mcnt[m] < 4) begin
            if (mprimed[m]) begin
              ev[m] = 1; echk[m] = 1; ed[m] = 1; eidx[m] = k;
              ere[m] = df_re[m][k]; eim[m] = df_im[m][k];
            end
            fa_re[m][k] = in_re; fa_im[m][k] = in_im;
          end else begin
            rr = bf(m, fa_re[m][k], in_re);
            ii = bf(m, fa_im[m][k], in_im);
            ev[m] = 1; echk[m] = 1; ed[m] = 0; eidx[m] = k;
            ere[m] = rr[31:16]; eim[m] = ii[31:16];
            df_re[m][k] = rr[15:0]; df_im[m][k] = ii[15:0];
            if (mcnt[m] == 7) mprimed[m] = 1;
          end
          mcnt[m] = (mcnt[m] + 1) % 8;
        end else if (flush && mcnt[m] == 0 && mprimed[m]) begin
          mdrain[m] = 1; mdc[m] = 0;
        end
      end
      erdy[m] = !mdrain[m];
    end
  end

  typedef struct { logic d; logic [1:0] idx; logic [15:0] re, im; } ent_t;
  ent_t q0[$], q1[$];

  // Per-cycle compare against the model, and log of every valid output.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("vld%0d", m), 32'(ov[m]), 32'(ev[m]));
        chk($sformatf("rdy%0d", m), 32'(ordy[m]), 32'(erdy[m]));
        if (echk[m]) begin
          chk($sformatf("re%0d", m),   32'(ore[m]),  32'(ere[m]));
          chk($sformatf("im%0d", m),   32'(oim[m]),  32'(eim[m]));
          chk($sformatf("diff%0d", m), 32'(odf[m]),  32'(ed[m]));
          chk($sformatf("idx%0d", m),  32'(oidx[m]), 32'(eidx[m][1:0]));
        end
        if (ov[m]) begin
          ent_t e;
          e.d = odf[m]; e.idx = oidx[m]; e.re = ore[m]; e.im = oim[m];
          if (m == 0) q0.push_back(e); else q1.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clrq();
    q0.delete();
    q1.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic feed(input int re0, input int im0, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; in_re = 16'(re0 + i); in_im = 16'(im0 + i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic chkq(input int m, input int pos, input string nm,
                      input int d, input int idx, input int re, input int im);
    ent_t e;
    int sz;
    sz = (m == 0) ? q0.size() : q1.size();
    ncmp++;
    if (pos >= sz) begin
      nerr++;
      $display("FAIL %s: output %0d missing, only %0d logged", nm, pos, sz);
    end else begin
      e = (m == 0) ? q0[pos] : q1[pos];
      chk({nm, ".d"},   32'(e.d),   32'(d[0]));
      chk({nm, ".idx"}, 32'(e.idx), 32'(idx[1:0]));
      chk({nm, ".re"},  32'(e.re),  32'(re[15:0]));
      chk({nm, ".im"},  32'(e.im),  32'(im[15:0]));
    end
  endtask

  initial begin
    // Reset held 3 cycles with live random input.
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_re = 16'($urandom); in_im = 16'($urandom);
      tick();
      chk_en = 1'b1;
    end
    rst = 1'b0; in_valid = 1'b0;

    // First frame after reset, then flush at the boundary.
    clrq();
    feed(1, 0, 8);
    flush = 1'b1; tick(); flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("drain_rdy", 32'(ordy[0]), 32'd0);
      tick();
    end
    chk("post_drain_rdy", 32'(ordy[0]), 32'd1);
    tick(); tick();
    chk("t1_cnt0", q0.size(), 8);
    chk("t1_cnt1", q1.size(), 8);
    for (int i = 0; i < 4; i++) begin
      chkq(0, i,     "t1_s0_sum", 0, i, 6 + 2*i, 4 + 2*i);
      chkq(0, 4 + i, "t1_s0_dif", 1, i, -4, -4);
      chkq(1, i,     "t1_s1_sum", 0, i, 3 + i, 2 + i);
      chkq(1, 4 + i, "t1_s1_dif", 1, i, -2, -2);
    end

    // Back-to-back frames without flush.
    do_reset(); clrq();
    feed(1, 0, 8);
    feed(9, 8, 8);
    tick(); tick();
    chk("t2_cnt0", q0.size(), 12);
    for (int i = 0; i < 4; i++) begin
      chkq(0, i,     "t2_f1_sum", 0, i, 6 + 2*i, 4 + 2*i);
      chkq(0, 4 + i, "t2_f2_dif", 1, i, -4, -4);
      chkq(0, 8 + i, "t2_f2_sum", 0, i, 22 + 2*i, 20 + 2*i);
      chkq(1, 8 + i, "t2_f2_sum1", 0, i, 11 + i, 10 + i);
    end

    // Stall mid phase B, then an overflow frame, then drain.
    do_reset(); clrq();
    feed(1, 0, 6);
    tick(); tick(); tick();
    feed(7, 6, 2);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_im = '0;
      in_re = (i == 0) ? 16'h7FFF : ((i == 4) ? 16'h0001 : 16'h0000);
      tick();
    end
    in_valid = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("t3_cnt0", q0.size(), 16);
    for (int i = 0; i < 4; i++) begin
      chkq(0, i,     "t3_sum", 0, i, 6 + 2*i, 4 + 2*i);
      chkq(0, 4 + i, "t3_dif", 1, i, -4, -4);
    end
    chkq(0, 8,  "t3_ovf_sum0", 0, 0, 32'h8000, 0);
    chkq(0, 9,  "t3_ovf_sum1", 0, 1, 0, 0);
    chkq(0, 12, "t3_ovf_dif0", 1, 0, 32'h7FFE, 0);
    chkq(1, 8,  "t3_ovf_sum0s", 0, 0, 32'h4000, 0);
    chkq(1, 12, "t3_ovf_dif0s", 1, 0, 32'h3FFF, 0);

    // Reset after two drain steps.
    do_reset();
    feed(1, 0, 8);
    flush = 1'b1; tick(); flush = 1'b0;
    tick(); tick();
    rst = 1'b1; tick();
    chk("t4_vld_after_rst", 32'(ov[0]), 32'd0);
    chk("t4_rdy_after_rst", 32'(ordy[0]), 32'd1);
    rst = 1'b0;
    clrq();
    feed(1, 0, 8);
    tick(); tick(); tick();
    chk("t4_cnt0", q0.size(), 4);
    for (int i = 0; i < 4; i++) chkq(0, i, "t4_sum", 0, i, 6 + 2*i, 4 + 2*i);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
